g_shi2: RTL and testbench

G_SHI2 -- requirements
Module: g_shi2

---
 rtl/g_shi2.sv | 76 +++++++
 tb/tb_g_shi2.sv | 128 ++++++++++++
 2 files changed

// File: rtl/g_shi2.sv
// Single-cycle fixed-distance shift stage (left / logical right / arithmetic right / rotate right).
// Rotate-right on Mode=11 only when G_SHI2_ROTATE_EN is defined; otherwise Mode=11 acts as logical right.
module g_shi2 #(
  parameter int WIDTH = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  input  logic             B,
  input  logic [1:0]       Mode,
  input  logic             InValid,
  output logic [WIDTH-1:0] Out,
  output logic [SHAMT-1:0] ShOut,
  output logic             OutValid
);

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_mode_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SHAMT-1:0] sh_q,  sh_d;
  logic             vld_q;

  // Right shifts all expose the same low bits as the carry-out chain.
  always_comb begin
    out_d = In;
    sh_d  = '0;
    if (B) begin
      unique case (sh_mode_e'(Mode))
        SH_LSL: begin
          out_d = {In[WIDTH-SHAMT-1:0], {SHAMT{1'b0}}};
          sh_d  = In[WIDTH-1 -: SHAMT];
        end
        SH_ASR: begin
          out_d = {{SHAMT{In[WIDTH-1]}}, In[WIDTH-1:SHAMT]};
          sh_d  = In[SHAMT-1:0];
        end
`ifdef G_SHI2_ROTATE_EN
        SH_ROR: begin
          out_d = {In[SHAMT-1:0], In[WIDTH-1:SHAMT]};
          sh_d  = In[SHAMT-1:0];
        end
`endif
        default: begin
          out_d = {{SHAMT{1'b0}}, In[WIDTH-1:SHAMT]};
          sh_d  = In[SHAMT-1:0];
        end
      endcase
    end
  end

  // Data registers only load on a valid op so results hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      sh_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= InValid;
      if (InValid) begin
        out_q <= out_d;
        sh_q  <= sh_d;
      end
    end
  end

  assign Out      = out_q;
  assign ShOut    = sh_q;
  assign OutValid = vld_q;

endmodule

// File: tb/tb_g_shi2.sv
// Directed + random bench for g_shi2: expected results queued at drive time, popped one cycle later.
module tb_g_shi2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] In;
  logic        B;
  logic [1:0]  Mode;
  logic        InValid;
  logic [31:0] Out;
  logic [1:0]  ShOut;
  logic        OutValid;

  typedef struct {
    logic [31:0] o;
    logic [1:0]  s;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_o;
  logic [1:0]  last_s;
  int          n_pass  = 0;
  int          n_total = 0;

  g_shi2 dut (
    .clk(clk), .rst(rst), .In(In), .B(B), .Mode(Mode), .InValid(InValid),
    .Out(Out), .ShOut(ShOut), .OutValid(OutValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model built on wide shifts rather than bit concatenation.
  function automatic exp_t model(input logic [31:0] x, input logic b, input logic [1:0] m);
    exp_t        e;
    logic [63:0] w;
    e.o = x;
    e.s = 2'b00;
    if (b) begin
      case (m)
        2'b00: begin w = {32'd0, x} << 2; e.o = w[31:0]; e.s = w[33:32]; end
        2'b10: begin w = $signed({x, 32'd0}) >>> 2; e.o = w[63:32]; e.s = w[31:30]; end
`ifdef G_SHI2_ROTATE_EN
        2'b11: begin w = {x, x} >> 2; e.o = w[31:0]; e.s = x[1:0]; end
`endif
        default: begin w = {x, 32'd0} >> 2; e.o = w[63:32]; e.s = w[31:30]; end
      endcase
    end
    return e;
  endfunction

  // One clock: drive inputs, queue expectation, advance, compare.
  task automatic cyc(input string tag, input logic r, input logic [31:0] x, input logic b,
                     input logic [1:0] m, input logic v, input logic [31:0] eo, input logic [1:0] es);
    exp_t e;
    rst = r; In = x; B = b; Mode = m; InValid = v;
    if (v && !r) begin
      e.o = eo; e.s = es;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) begin
      check({tag, ".out"}, Out, 32'd0);
      check({tag, ".sh"}, {30'd0, ShOut}, 32'd0);
      check({tag, ".vld"}, {31'd0, OutValid}, 32'd0);
      last_o = 32'd0; last_s = 2'b00;
    end else if (v) begin
      e = sb.pop_front();
      check({tag, ".out"}, Out, e.o);
      check({tag, ".sh"}, {30'd0, ShOut}, {30'd0, e.s});
      check({tag, ".vld"}, {31'd0, OutValid}, 32'd1);
      last_o = e.o; last_s = e.s;
    end else begin
      check({tag, ".hold_out"}, Out, last_o);
      check({tag, ".hold_sh"}, {30'd0, ShOut}, {30'd0, last_s});
      check({tag, ".vld"}, {31'd0, OutValid}, 32'd0);
    end
  endtask

  task automatic rnd(input string tag, input logic v);
    logic [31:0] x;
    logic        b;
    logic [1:0]  m;
    exp_t        e;
    x = $urandom; b = 1'($urandom_range(0, 1)); m = 2'($urandom_range(0, 3));
    e = model(x, b, m);
    cyc(tag, 1'b0, x, b, m, v, e.o, e.s);
  endtask

  initial begin
    last_o = 32'd0; last_s = 2'b00;
    cyc("reset0", 1'b1, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b1, 32'd0, 2'b00);
    cyc("reset1", 1'b1, 32'h1234_5678, 1'b0, 2'b01, 1'b0, 32'd0, 2'b00);
    cyc("idle",   1'b0, 32'h0,         1'b0, 2'b00, 1'b0, 32'd0, 2'b00);

    cyc("lsl",    1'b0, 32'hA010_4010, 1'b1, 2'b00, 1'b1, 32'h8041_0040, 2'b10);
    cyc("lsr",    1'b0, 32'hA010_4010, 1'b1, 2'b01, 1'b1, 32'h2804_1004, 2'b00);
    cyc("asr",    1'b0, 32'hA010_4010, 1'b1, 2'b10, 1'b1, 32'hE804_1004, 2'b00);
    cyc("byp0",   1'b0, 32'hA010_4010, 1'b0, 2'b00, 1'b1, 32'hA010_4010, 2'b00);
    cyc("byp3",   1'b0, 32'hA010_4010, 1'b0, 2'b11, 1'b1, 32'hA010_4010, 2'b00);
`ifdef G_SHI2_ROTATE_EN
    cyc("ror",    1'b0, 32'h0000_0003, 1'b1, 2'b11, 1'b1, 32'hC000_0000, 2'b11);
`else
    cyc("ror_off",1'b0, 32'h0000_0003, 1'b1, 2'b11, 1'b1, 32'h0000_0000, 2'b11);
`endif
    cyc("asr_pos",1'b0, 32'h7FFF_FFFF, 1'b1, 2'b10, 1'b1, 32'h1FFF_FFFF, 2'b11);
    cyc("lsl_top",1'b0, 32'hC000_0001, 1'b1, 2'b00, 1'b1, 32'h0000_0004, 2'b11);
    cyc("hold0",  1'b0, 32'h5555_5555, 1'b1, 2'b01, 1'b0, 32'd0, 2'b00);
    cyc("hold1",  1'b0, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 32'd0, 2'b00);

    for (int i = 0; i < 40; i++) rnd("rand", 1'($urandom_range(0, 3) != 0));

    cyc("pre_rst",1'b0, 32'hA010_4010, 1'b1, 2'b00, 1'b1, 32'h8041_0040, 2'b10);
    cyc("mid_rst",1'b1, 32'hA010_4010, 1'b1, 2'b10, 1'b1, 32'd0, 2'b00);
    cyc("post0",  1'b0, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 32'd0, 2'b00);
    cyc("post1",  1'b0, 32'h8000_0000, 1'b1, 2'b10, 1'b1, 32'hE000_0000, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
